// File: rtl/fpu_defs.sv
// Shared widths, types and constants for the FP add/sub normalize-and-round path.
package fpu_defs;

    localparam int unsigned C_EXP          = 8;
    localparam int unsigned C_MANT         = 23;
    localparam int unsigned C_EXP_PRENORM  = 10;
    localparam int unsigned C_MANT_PRENORM = 48;

    localparam logic [C_EXP-1:0] C_EXP_INF        = 8'hFF;
    localparam int unsigned      C_MANT_ROUND_LSB = 23;

    typedef enum logic [1:0] {
        RmRne = 2'b00,
        RmRtz = 2'b01,
        RmRup = 2'b10,
        RmRdn = 2'b11
    } rm_e;

    typedef struct packed {
        logic                             sign;
        logic signed [C_EXP_PRENORM-1:0]  exp;
        logic        [C_MANT_PRENORM-1:0] mant;
    } prenorm_t;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StRound,
        StOut
    } state_e;

endpackage

// File: rtl/fpu_lzc47.sv
// Combinational leading-zero counter over 47 bits; count is 47 when the input is all zero.
module fpu_lzc47 (
    input  logic [46:0] data_i,
    output logic [5:0]  cnt_o,
    output logic        zero_o
);

    always_comb begin
        cnt_o = 6'd47;
        // Ascending scan: the highest set bit is written last and wins.
        for (int i = 0; i <= 46; i++) begin
            if (data_i[i]) begin
                cnt_o = 6'(46 - i);
            end
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/fpu_norm_round_seq.sv
// Multi-cycle normalize-and-round stage: prenorm {sign, exp, mant} in, packed binary32 and
// IEEE flags out. One operation in flight, walking IDLE -> NORM -> ROUND -> OUT.
module fpu_norm_round_seq
    import fpu_defs::*;
(
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic                      Valid_SI,
    output logic                      Ready_SO,
    input  logic [1:0]                RM_SI,
    input  logic                      Sign_prenorm_DI,
    input  logic [C_EXP_PRENORM-1:0]  Exp_prenorm_DI,
    input  logic [C_MANT_PRENORM-1:0] Mant_prenorm_DI,
    output logic                      Valid_SO,
    input  logic                      Ready_SI,
    output logic [31:0]               Result_DO,
    output logic                      OF_SO,
    output logic                      UF_SO,
    output logic                      NX_SO,
    output logic                      Zero_SO
);

    localparam logic [30:0] C_MAG_INF = {C_EXP_INF, {C_MANT{1'b0}}};
    localparam logic [30:0] C_MAG_MAX = {C_EXP_INF - 8'd1, {C_MANT{1'b1}}};

    state_e   state_q, state_d;
    prenorm_t in_q, in_d;
    rm_e      rm_q, rm_d;

    logic [46:0] nmant_q, nmant_d;
    logic        nsticky_q, nsticky_d;
    logic [9:0]  nexp_q, nexp_d;
    logic        nzero_q, nzero_d;

    logic [31:0] res_q, res_d;
    logic        of_q, of_d, uf_q, uf_d, nx_q, nx_d, zero_q, zero_d;

    // FSM: state register
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (Valid_SI) state_d = StNorm;
            StNorm:  state_d = StRound;
            StRound: state_d = StOut;
            StOut:   if (Ready_SI) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        Ready_SO = (state_q == StIdle);
        Valid_SO = (state_q == StOut);
    end

    always_comb begin
        in_d = in_q;
        rm_d = rm_q;
        if (state_q == StIdle && Valid_SI) begin
            in_d.sign = Sign_prenorm_DI;
            in_d.exp  = $signed(Exp_prenorm_DI);
            in_d.mant = Mant_prenorm_DI;
            rm_d      = rm_e'(RM_SI);
        end
    end

    // ---------------- Normalization ----------------
    logic [46:0]        m1;
    logic               s1;
    logic signed [10:0] e1, e_minus_l, sh_full;
    logic [5:0]         lzc_cnt, sh_r;
    logic               lzc_zero;
    logic [95:0]        ext;

    // A carry in bit 47 is folded in first, then the 47-bit value is normalized.
    always_comb begin
        if (in_q.mant[47]) begin
            m1 = in_q.mant[47:1];
            s1 = in_q.mant[0];
            e1 = {in_q.exp[C_EXP_PRENORM-1], in_q.exp} + 11'sd1;
        end else begin
            m1 = in_q.mant[46:0];
            s1 = 1'b0;
            e1 = {in_q.exp[C_EXP_PRENORM-1], in_q.exp};
        end
    end

    fpu_lzc47 u_lzc (
        .data_i (m1),
        .cnt_o  (lzc_cnt),
        .zero_o (lzc_zero)
    );

    always_comb begin
        e_minus_l = e1 - $signed({5'b0, lzc_cnt});
        sh_full   = 11'sd1 - e1;
        sh_r      = (sh_full > 11'sd48) ? 6'd48 : sh_full[5:0];
        ext       = {m1, 49'b0} >> sh_r;

        nmant_d   = nmant_q;
        nsticky_d = nsticky_q;
        nexp_d    = nexp_q;
        nzero_d   = nzero_q;
        if (state_q == StNorm) begin
            nzero_d   = lzc_zero;
            nsticky_d = s1;
            nexp_d    = '0;
            if (lzc_zero) begin
                nmant_d = '0;
            end else if (e_minus_l >= 11'sd1) begin
                nmant_d = m1 << lzc_cnt;
                nexp_d  = e_minus_l[9:0];
            end else if (e1 >= 11'sd1) begin
                // Denormal: shift only as far as the minimum exponent allows.
                nmant_d = m1 << 6'(e1 - 11'sd1);
            end else begin
                nmant_d   = ext[95:49];
                nsticky_d = s1 | (|ext[48:0]);
            end
        end
    end

    // ---------------- Rounding ----------------
    logic        lsb, grd, rnd, stk, inexact, rnd_up;
    logic [24:0] sum;
    logic [22:0] m23;
    logic [9:0]  exp_r;
    logic [30:0] mag;

    always_comb begin
        lsb     = nmant_q[C_MANT_ROUND_LSB];
        grd     = nmant_q[22];
        rnd     = nmant_q[21];
        stk     = (|nmant_q[20:0]) | nsticky_q;
        inexact = grd | rnd | stk;

        unique case (rm_q)
            RmRne:   rnd_up = grd & (rnd | stk | lsb);
            RmRtz:   rnd_up = 1'b0;
            RmRup:   rnd_up = inexact & ~in_q.sign;
            RmRdn:   rnd_up = inexact & in_q.sign;
            default: rnd_up = 1'b0;
        endcase

        sum   = {1'b0, nmant_q[46:23]} + {24'b0, rnd_up};
        m23   = sum[22:0];
        exp_r = nexp_q;
        if (sum[24]) begin
            m23   = '0;
            exp_r = nexp_q + 10'd1;
        end else if (nexp_q == '0 && sum[23]) begin
            exp_r = 10'd1;
        end

        unique case (rm_q)
            RmRne:   mag = C_MAG_INF;
            RmRtz:   mag = C_MAG_MAX;
            RmRup:   mag = in_q.sign ? C_MAG_MAX : C_MAG_INF;
            RmRdn:   mag = in_q.sign ? C_MAG_INF : C_MAG_MAX;
            default: mag = C_MAG_INF;
        endcase

        res_d  = res_q;
        of_d   = of_q;
        uf_d   = uf_q;
        nx_d   = nx_q;
        zero_d = zero_q;
        if (state_q == StRound) begin
            of_d   = 1'b0;
            uf_d   = 1'b0;
            nx_d   = 1'b0;
            zero_d = 1'b0;
            if (nzero_q) begin
                res_d  = {rm_q == RmRdn, 31'b0};
                zero_d = 1'b1;
            end else if (exp_r >= 10'd255) begin
                res_d = {in_q.sign, mag};
                of_d  = 1'b1;
                nx_d  = 1'b1;
            end else begin
                res_d  = {in_q.sign, exp_r[7:0], m23};
                nx_d   = inexact;
                uf_d   = inexact & (nexp_q == '0);
                zero_d = (exp_r == '0) && (m23 == '0);
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            in_q      <= '0;
            rm_q      <= RmRne;
            nmant_q   <= '0;
            nsticky_q <= 1'b0;
            nexp_q    <= '0;
            nzero_q   <= 1'b0;
            res_q     <= '0;
            of_q      <= 1'b0;
            uf_q      <= 1'b0;
            nx_q      <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            in_q      <= in_d;
            rm_q      <= rm_d;
            nmant_q   <= nmant_d;
            nsticky_q <= nsticky_d;
            nexp_q    <= nexp_d;
            nzero_q   <= nzero_d;
            res_q     <= res_d;
            of_q      <= of_d;
            uf_q      <= uf_d;
            nx_q      <= nx_d;
            zero_q    <= zero_d;
        end
    end

    assign Result_DO = res_q;
    assign OF_SO     = of_q;
    assign UF_SO     = uf_q;
    assign NX_SO     = nx_q;
    assign Zero_SO   = zero_q;

endmodule

// File: tb/tb_fpu_norm_round_seq.sv
// Scoreboard bench for fpu_norm_round_seq: driver queues expected results, monitor checks them.
module tb_fpu_norm_round_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  rm_i = 2'b00;
    logic        sign_i = 1'b0;
    logic [9:0]  exp_i = '0;
    logic [47:0] mant_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] res_o;
    logic        of_o, uf_o, nx_o, zero_o;

    always #5 clk = ~clk;

    fpu_norm_round_seq dut (
        .Clk_CI          (clk),
        .Rst_RBI         (rst_n),
        .Valid_SI        (valid_i),
        .Ready_SO        (ready_o),
        .RM_SI           (rm_i),
        .Sign_prenorm_DI (sign_i),
        .Exp_prenorm_DI  (exp_i),
        .Mant_prenorm_DI (mant_i),
        .Valid_SO        (valid_o),
        .Ready_SI        (ready_i),
        .Result_DO       (res_o),
        .OF_SO           (of_o),
        .UF_SO           (uf_o),
        .NX_SO           (nx_o),
        .Zero_SO         (zero_o)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  fl;  // {OF, UF, NX, Zero}
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   k;
    logic seen;

    localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RUP = 2'b10, RDN = 2'b11;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endfunction

    // Monitor: compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h, required no output", res_o);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_result"}, res_o, mon_e.res);
                chk({mon_e.name, "_flags"}, {28'b0, of_o, uf_o, nx_o, zero_o}, {28'b0, mon_e.fl});
            end
        end
    end

    task automatic send(input string nm, input logic s, input logic [9:0] e, input logic [47:0] m,
                        input logic [1:0] rm, input logic [31:0] res, input logic [3:0] fl);
        int   w;
        int   lat;
        exp_t x;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!ready_o && w < 20);
        sign_i  = s;
        exp_i   = e;
        mant_i  = m;
        rm_i    = rm;
        valid_i = 1'b1;
        x.name  = nm;
        x.res   = res;
        x.fl    = fl;
        sb_q.push_back(x);
        @(posedge clk);
        #1 valid_i = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid_o && lat < 10);
        chk({nm, "_latency"}, lat, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_result", res_o, 0);
        chk("rst_flags", {28'b0, of_o, uf_o, nx_o, zero_o}, 0);

        send("carry_rne",   0, 10'd127, 48'h8000_0000_0000, RNE, 32'h4000_0000, 4'b0000);
        send("zero_rne",    0, 10'd100, 48'h0000_0000_0000, RNE, 32'h0000_0000, 4'b0001);
        send("zero_rdn",    0, 10'd100, 48'h0000_0000_0000, RDN, 32'h8000_0000, 4'b0001);
        send("tie_even",    0, 10'd127, 48'h4000_0040_0000, RNE, 32'h3F80_0000, 4'b0010);
        send("tie_odd",     0, 10'd127, 48'h4000_00C0_0000, RNE, 32'h3F80_0002, 4'b0010);
        send("rup_pos",     0, 10'd127, 48'h4000_00C0_0000, RUP, 32'h3F80_0002, 4'b0010);
        send("ovf_rne",     0, 10'd254, 48'h8000_0000_0000, RNE, 32'h7F80_0000, 4'b1010);
        send("ovf_rtz",     0, 10'd254, 48'h8000_0000_0000, RTZ, 32'h7F7F_FFFF, 4'b1010);
        send("ovf_rup_neg", 1, 10'd254, 48'h8000_0000_0000, RUP, 32'hFF7F_FFFF, 4'b1010);
        send("lshift6",     0, 10'd10,  48'h0100_0000_0000, RNE, 32'h0200_0000, 4'b0000);
        send("denorm_l",    0, 10'd3,   48'h0100_0000_0000, RNE, 32'h0008_0000, 4'b0000);
        send("rshift_uf",   0, 10'd0,   48'h4000_0000_0001, RNE, 32'h0040_0000, 4'b0110);
        send("mant_carry",  0, 10'd127, 48'h7FFF_FFC0_0000, RNE, 32'h4000_0000, 4'b0010);
        send("den_to_norm", 0, 10'd0,   48'h7FFF_FF80_0000, RNE, 32'h0080_0000, 4'b0110);
        send("rdn_neg",     1, 10'd127, 48'h4000_0020_0000, RDN, 32'hBF80_0001, 4'b0010);
        send("rne_neg",     1, 10'd127, 48'h4000_0020_0000, RNE, 32'hBF80_0000, 4'b0010);

        // Backpressure: hold Ready_SI low while junk is offered on the input side.
        @(posedge clk);
        #1 ready_i = 1'b0;
        send("bp", 0, 10'd127, 48'h4000_0040_0000, RNE, 32'h3F80_0000, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_hold", valid_o, 1);
            chk("bp_result_hold", res_o, 32'h3F80_0000);
            chk("bp_ready_low", ready_o, 0);
            valid_i = 1'b1;
            exp_i   = 10'd200;
            mant_i  = 48'h8000_0000_0000;
            @(negedge clk);
        end
        @(posedge clk);
        #1 valid_i = 1'b0;
        ready_i = 1'b1;

        // Reset pulse while in NORM aborts the operation.
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ready_o && k < 20);
        sign_i  = 1'b0;
        exp_i   = 10'd127;
        mant_i  = 48'h8000_0000_0000;
        rm_i    = RNE;
        valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_ready_async", ready_o, 1);
        chk("rstmid_valid_async", valid_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rstmid_ready", ready_o, 1);
        chk("rstmid_result_cleared", res_o, 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        chk("rstmid_no_output", seen, 0);

        send("post_rst", 0, 10'd127, 48'h8000_0000_0000, RNE, 32'h4000_0000, 4'b0000);

        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
